// File: rtl/sh_multi_intc.sv
// ---------------------------------------------------------------------------
// sh_multi_intc
// Multi-source interrupt controller that presents one prioritised interrupt
// (level, vector and source index) to a CPU with an SR.I-style mask.
//
// Optional feature macro: SH_MULTI_INTC_NMI_EN
//   When defined, input NMI_N is added. A registered falling edge on NMI_N
//   raises a non-maskable request that beats every source, presented as
//   level 15, vector 11, source 63, and cleared on acknowledge.
//
// Ports
//   CLK, RST_N        clock, synchronous active-low reset (overrides CE)
//   CE                clock enable for all state
//   NMI_N             (NMI build only) active-low non-maskable request
//   SRC_IRQ[NSRC]     per-source request, active high
//   INT_MASK[4]       CPU mask level; requests need level > mask
//   INT_ACK           one-cycle acknowledge from the CPU
//   INT_REQ/LVL/VEC/SRC  presented interrupt (registered)
//   REG_ADDR/WE/RE/DI/DO per-source config register port
//     layout: [15:12] level, [11] edge mode, [10] pending (RO),
//             [9] clear-pending (WO, reads 0), [VECW-1:0] vector
// ---------------------------------------------------------------------------
module sh_multi_intc #(
    parameter int NSRC = 16,
    parameter int VECW = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE,
`ifdef SH_MULTI_INTC_NMI_EN
    input  logic              NMI_N,
`endif
    input  logic [NSRC-1:0]   SRC_IRQ,
    input  logic [3:0]        INT_MASK,
    input  logic              INT_ACK,
    output logic              INT_REQ,
    output logic [3:0]        INT_LVL,
    output logic [VECW-1:0]   INT_VEC,
    output logic [5:0]        INT_SRC,
    input  logic [5:0]        REG_ADDR,
    input  logic              REG_WE,
    input  logic              REG_RE,
    input  logic [15:0]       REG_DI,
    output logic [15:0]       REG_DO
);

    localparam int AW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic {S_IDLE, S_ACKD} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        lvl_reg [NSRC];
    logic [VECW-1:0]   vec_reg [NSRC];
    logic [NSRC-1:0]   edge_reg;
    logic [NSRC-1:0]   irq_s_reg, irq_p_reg, pend_reg, pend_next;

    logic              addr_ok, wr_en, rd_en;
    logic [AW-1:0]     addr_idx;
    logic [15:0]       rd_word;
    logic              ack_fire, load_out;
    logic              win_valid, win_nmi, req_ok;
    logic [3:0]        win_lvl;
    logic [5:0]        win_idx;
    logic [VECW-1:0]   win_vec;
    logic              nmi_sel;

    // Bits [10] and [8:VECW] of REG_DI have no write target.
    logic              unused_bits;
    assign unused_bits = ^REG_DI;

    assign addr_ok  = int'(REG_ADDR) < NSRC;
    assign addr_idx = REG_ADDR[AW-1:0];
    assign wr_en    = CE && REG_WE && addr_ok;
    assign rd_en    = CE && REG_RE;

    // ---------------- per-source pending logic ----------------
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        logic wr_hit, rise, clr, mode_chg;
        assign wr_hit   = wr_en && (addr_idx == AW'(gi));
        assign rise     = irq_s_reg[gi] & ~irq_p_reg[gi];
        // An acknowledge only clears the source that is actually presented.
        assign clr      = (ack_fire && !nmi_sel && (INT_SRC == 6'(gi)))
                        | (wr_hit && REG_DI[9]);
        assign mode_chg = wr_hit && (REG_DI[11] != edge_reg[gi]);
        // Edge mode: a new edge wins over a clear in the same cycle.
        assign pend_next[gi] = mode_chg      ? 1'b0 :
                               edge_reg[gi]  ? (rise | (pend_reg[gi] & ~clr)) :
                                               irq_s_reg[gi];
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            irq_s_reg <= '0;
            irq_p_reg <= '0;
            pend_reg  <= '0;
            edge_reg  <= '0;
            for (int i = 0; i < NSRC; i++) begin
                lvl_reg[i] <= '0;
                vec_reg[i] <= '0;
            end
        end else if (CE) begin
            irq_s_reg <= SRC_IRQ;
            irq_p_reg <= irq_s_reg;
            pend_reg  <= pend_next;
            if (wr_en) begin
                lvl_reg[addr_idx]  <= REG_DI[15:12];
                edge_reg[addr_idx] <= REG_DI[11];
                vec_reg[addr_idx]  <= REG_DI[VECW-1:0];
            end
        end
    end

    // ---------------- register read-back ----------------
    always_comb begin
        rd_word = '0;
        if (addr_ok) begin
            rd_word[15:12]     = lvl_reg[addr_idx];
            rd_word[11]        = edge_reg[addr_idx];
            rd_word[10]        = pend_reg[addr_idx];
            rd_word[VECW-1:0]  = vec_reg[addr_idx];
        end
    end

    // Read sees state before any same-cycle write.
    always_ff @(posedge CLK) begin
        if (!RST_N)
            REG_DO <= '0;
        else if (rd_en)
            REG_DO <= rd_word;
    end

    // ---------------- optional NMI ----------------
`ifdef SH_MULTI_INTC_NMI_EN
    logic nmi_s_reg, nmi_p_reg, nmi_pend_reg, nmi_sel_reg;
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            nmi_s_reg    <= 1'b1;
            nmi_p_reg    <= 1'b1;
            nmi_pend_reg <= 1'b0;
        end else if (CE) begin
            nmi_s_reg    <= NMI_N;
            nmi_p_reg    <= nmi_s_reg;
            nmi_pend_reg <= (nmi_p_reg & ~nmi_s_reg)
                          | (nmi_pend_reg & ~(ack_fire && nmi_sel_reg));
        end
    end
    assign nmi_sel = nmi_sel_reg;
`else
    assign nmi_sel = 1'b0;
`endif

    // ---------------- arbitration ----------------
    // Strict '>' keeps the lowest index on ties and excludes level 0.
    always_comb begin
        win_valid = 1'b0;
        win_nmi   = 1'b0;
        win_lvl   = '0;
        win_idx   = '0;
        win_vec   = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (pend_reg[i] && (lvl_reg[i] > win_lvl)) begin
                win_valid = 1'b1;
                win_lvl   = lvl_reg[i];
                win_idx   = 6'(i);
                win_vec   = vec_reg[i];
            end
        end
`ifdef SH_MULTI_INTC_NMI_EN
        if (nmi_pend_reg) begin
            win_valid = 1'b1;
            win_nmi   = 1'b1;
            win_lvl   = 4'd15;
            win_idx   = 6'd63;
            win_vec   = VECW'(11);
        end
`endif
        req_ok = win_valid && (win_nmi || (win_lvl > INT_MASK));
    end

    // ---------------- acknowledge FSM ----------------
    always_ff @(posedge CLK) begin
        if (!RST_N)
            state_reg <= S_IDLE;
        else if (CE)
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (INT_ACK && INT_REQ) state_next = S_ACKD;
            S_ACKD:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ack_fire = CE && (state_reg == S_IDLE) && INT_ACK && INT_REQ;
        load_out = (state_reg == S_IDLE) && !(INT_ACK && INT_REQ) && req_ok;
    end

    // Presented interrupt; LVL/VEC/SRC only change when a request is loaded.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            INT_REQ <= 1'b0;
            INT_LVL <= '0;
            INT_VEC <= '0;
            INT_SRC <= '0;
        end else if (CE) begin
            INT_REQ <= load_out;
            if (load_out) begin
                INT_LVL <= win_lvl;
                INT_VEC <= win_vec;
                INT_SRC <= win_idx;
            end
        end
    end

`ifdef SH_MULTI_INTC_NMI_EN
    always_ff @(posedge CLK) begin
        if (!RST_N)
            nmi_sel_reg <= 1'b0;
        else if (CE && load_out)
            nmi_sel_reg <= win_nmi;
    end
`endif

endmodule
